ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/ram_arb_spram.sv | 43 ++++
 rtl/ram_port_arbiter.sv | 139 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and latency constants for the two-port RAM arbiter.
// ARB_OUTPUT_REG_EN adds an output register stage to the RAM read path.
package ram_arb_pkg;

    localparam int NUM_REQ = 2;

`ifdef ARB_OUTPUT_REG_EN
    localparam int READ_LAT = 2;
`else
    localparam int READ_LAT = 1;
`endif

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/ram_arb_spram.sv
// Single-port RAM with a no-change read register and an optional output register.
// ARB_OUTPUT_REG_EN enables the output register stage.
module ram_arb_spram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rd_p0;

    // stage p0: array access; a write leaves the read register untouched
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rd_p0 <= mem[addr];
            end
        end
    end

`ifdef ARB_OUTPUT_REG_EN
    logic [DATA_W-1:0] out_p1;

    // stage p1: output register
    always_ff @(posedge clk) begin
        out_p1 <= rd_p0;
    end

    assign rdata = out_p1;
`else
    assign rdata = rd_p0;
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters.
// ARB_OUTPUT_REG_EN raises read latency from 1 to 2 cycles.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic              req_we_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    output logic              rsp_valid_0,
    output logic [DATA_W-1:0] rsp_rdata_0,
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic              req_we_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_rdata_1,
    output logic              busy
);

    req_id_t           ptr;
    req_id_t           winner;
    logic              xfer;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              vld_last;
    req_id_t           id_last;

    // Ready is forced low while reset is held so no transfer can slip in.
    always_comb begin
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        if (rsta_n) begin
            if (req_valid_0 && (!req_valid_1 || ptr == REQ0)) begin
                req_ready_0 = 1'b1;
            end else if (req_valid_1) begin
                req_ready_1 = 1'b1;
            end
        end
    end

    assign xfer      = req_ready_0 | req_ready_1;
    assign winner    = req_ready_1 ? REQ1 : REQ0;
    assign sel_we    = req_ready_1 ? req_we_1    : req_we_0;
    assign sel_addr  = req_ready_1 ? req_addr_1  : req_addr_0;
    assign sel_wdata = req_ready_1 ? req_wdata_1 : req_wdata_0;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            ptr <= REQ0;
        end else if (xfer) begin
            ptr <= ~winner;
        end
    end

    ram_arb_spram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_spram (
        .clk   (clka),
        .en    (xfer),
        .we    (sel_we),
        .addr  (sel_addr),
        .wdata (sel_wdata),
        .rdata (ram_rdata)
    );

    logic    vld_p0;
    req_id_t id_p0;

    // stage p0: read issued into the RAM
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= xfer & ~sel_we;
        end
    end

    always_ff @(posedge clka) begin
        id_p0 <= winner;
    end

`ifdef ARB_OUTPUT_REG_EN
    logic    vld_p1;
    req_id_t id_p1;

    // stage p1: read data moving through the output register
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clka) begin
        id_p1 <= id_p0;
    end

    assign vld_last = vld_p1;
    assign id_last  = id_p1;
    assign busy     = vld_p0 | vld_p1;
`else
    assign vld_last = vld_p0;
    assign id_last  = id_p0;
    assign busy     = vld_p0;
`endif

    // response stage: steer the returning word to its requester and hold it
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rsp_rdata_0 <= '0;
            rsp_rdata_1 <= '0;
        end else begin
            rsp_valid_0 <= vld_last && (id_last == REQ0);
            rsp_valid_1 <= vld_last && (id_last == REQ1);
            if (vld_last && (id_last == REQ0)) begin
                rsp_rdata_0 <= ram_rdata;
            end
            if (vld_last && (id_last == REQ1)) begin
                rsp_rdata_1 <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed scenarios followed by random traffic.
// Latency expectations follow READ_LAT, so the same bench serves both builds.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    logic       clka = 1'b0;
    logic       rsta_n;
    logic       req_valid_0, req_ready_0, req_we_0;
    logic [7:0] req_addr_0, req_wdata_0;
    logic       rsp_valid_0;
    logic [7:0] rsp_rdata_0;
    logic       req_valid_1, req_ready_1, req_we_1;
    logic [7:0] req_addr_1, req_wdata_1;
    logic       rsp_valid_1;
    logic [7:0] rsp_rdata_1;
    logic       busy;

    ram_port_arbiter #(.DATA_W(8), .DEPTH(256)) dut (
        .clka(clka), .rsta_n(rsta_n),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
        .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
        .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
        .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
        .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
        .busy(busy)
    );

    always #5 clka = ~clka;

    typedef struct {
        logic [7:0] data;
        int         xfer;
        int         due;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] mmem [256];
    int         mptr;
    logic [7:0] last0, last1;
    int         cyc;
    int         checks;
    int         errors;
    logic       dut_g0, dut_g1;

    always @(posedge clka) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: lone requester wins; when both ask, the pointer decides and
    // then points at the loser. Reads return the word as of the transfer edge.
    task automatic step(input logic v0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                        input logic v1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
        logic e0, e1;
        exp_t e;
        @(posedge clka);
        #1;
        req_valid_0 = v0; req_we_0 = w0; req_addr_0 = a0; req_wdata_0 = d0;
        req_valid_1 = v1; req_we_1 = w1; req_addr_1 = a1; req_wdata_1 = d1;
        @(negedge clka);
        e0 = v0 && (!v1 || mptr == 0);
        e1 = v1 && !e0;
        dut_g0 = req_ready_0;
        dut_g1 = req_ready_1;
        chk("ready0", req_ready_0, e0);
        chk("ready1", req_ready_1, e1);
        if (e0 || e1) begin
            if (e0 ? w0 : w1) begin
                mmem[e0 ? a0 : a1] = e0 ? d0 : d1;
            end else begin
                e.data = mmem[e0 ? a0 : a1];
                e.xfer = cyc + 1;
                e.due  = cyc + 1 + READ_LAT;
                if (e0) q0.push_back(e); else q1.push_back(e);
            end
            mptr = e0 ? 1 : 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int hold);
        @(posedge clka);
        #1;
        rsta_n = 1'b0;
        q0.delete();
        q1.delete();
        mptr  = 0;
        last0 = '0;
        last1 = '0;
        #1;
        chk("rst_ready0", req_ready_0, 0);
        chk("rst_ready1", req_ready_1, 0);
        chk("rst_rsp_valid0", rsp_valid_0, 0);
        chk("rst_rsp_valid1", rsp_valid_1, 0);
        chk("rst_rdata0", rsp_rdata_0, 0);
        chk("rst_rdata1", rsp_rdata_1, 0);
        chk("rst_busy", busy, 0);
        repeat (hold) @(posedge clka);
        #1;
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        rsta_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every response pulse, checks hold and busy.
    initial begin
        exp_t e;
        logic exp_busy;
        forever begin
            @(negedge clka);
            #1;
            exp_busy = 1'b0;
            foreach (q0[k]) if (q0[k].xfer <= cyc && cyc < q0[k].due) exp_busy = 1'b1;
            foreach (q1[k]) if (q1[k].xfer <= cyc && cyc < q1[k].due) exp_busy = 1'b1;
            chk("busy", busy, exp_busy);
            if (rsp_valid_0) begin
                if (q0.size() == 0) begin
                    chk("rsp0_spurious", rsp_valid_0, 0);
                end else begin
                    e = q0.pop_front();
                    chk("rsp0_data", rsp_rdata_0, e.data);
                    chk("rsp0_cycle", cyc, e.due);
                    last0 = e.data;
                end
            end else begin
                chk("rsp0_hold", rsp_rdata_0, last0);
            end
            if (rsp_valid_1) begin
                if (q1.size() == 0) begin
                    chk("rsp1_spurious", rsp_valid_1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("rsp1_data", rsp_rdata_1, e.data);
                    chk("rsp1_cycle", cyc, e.due);
                    last1 = e.data;
                end
            end else begin
                chk("rsp1_hold", rsp_rdata_1, last1);
            end
        end
    end

    initial begin
        logic       p0, p1, w0, w1;
        logic [7:0] a0, a1, d0, d1;
        int         wait0, wait1;
        cyc = 0; checks = 0; errors = 0; mptr = 0;
        last0 = '0; last1 = '0;
        for (int i = 0; i < 256; i++) mmem[i] = '0;
        rsta_n = 1'b0;
        req_valid_0 = 0; req_we_0 = 0; req_addr_0 = 0; req_wdata_0 = 0;
        req_valid_1 = 0; req_we_1 = 0; req_addr_1 = 0; req_wdata_1 = 0;
        repeat (3) @(posedge clka);
        #1 rsta_n = 1'b1;

        // zero-initialised RAM, then preload through requester 1
        step(1, 0, 8'h33, 0, 0, 0, 0, 0);
        idle(READ_LAT + 1);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, 1, 8'(i), 8'(i * 37 + 11));
        do_reset(2);

        // continuous reads from both with pointer at 0: strict alternation
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 8'(i), 0, 1, 0, 8'(i + 8), 0);
            chk("rr_alternate", dut_g1, 32'(i % 2));
        end
        idle(READ_LAT + 2);

        // write then immediate read of the same address
        step(1, 1, 8'h10, 8'hA5, 0, 0, 0, 0);
        step(1, 0, 8'h10, 0, 0, 0, 0, 0);
        idle(READ_LAT + 2);

        // read old data, write, read new data
        step(1, 1, 8'h20, 8'h3C, 0, 0, 0, 0);
        idle(1);
        step(1, 0, 8'h20, 0, 0, 0, 0, 0);
        step(1, 1, 8'h20, 8'h77, 0, 0, 0, 0);
        step(1, 0, 8'h20, 0, 0, 0, 0, 0);
        idle(READ_LAT + 2);

        // pointer at 1: req1 write beats req0 read of the same word
        step(1, 0, 8'h00, 0, 0, 0, 0, 0);
        step(1, 0, 8'h05, 0, 1, 1, 8'h05, 8'h11);
        step(1, 0, 8'h05, 0, 0, 0, 0, 0);
        idle(READ_LAT + 2);

        // reset the cycle after a read transfer: the read must vanish
        step(1, 0, 8'h03, 0, 1, 0, 8'h04, 0);
        do_reset(2);
        idle(READ_LAT + 3);

        // random traffic with requests held until granted
        p0 = 0; p1 = 0; wait0 = 0; wait1 = 0;
        w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        for (int n = 0; n < 400; n++) begin
            if (!p0) begin
                p0 = 1'($urandom_range(0, 1)); w0 = 1'($urandom_range(0, 1));
                a0 = 8'($urandom_range(0, 15)); d0 = 8'($urandom);
            end
            if (!p1) begin
                p1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
                a1 = 8'($urandom_range(0, 15)); d1 = 8'($urandom);
            end
            step(p0, w0, a0, d0, p1, w1, a1, d1);
            if (p0) begin
                if (dut_g0) begin
                    chk("starve0", (wait0 <= 2), 1);
                    p0 = 0; wait0 = 0;
                end else begin
                    wait0++;
                end
            end
            if (p1) begin
                if (dut_g1) begin
                    chk("starve1", (wait1 <= 2), 1);
                    p1 = 0; wait1 = 0;
                end else begin
                    wait1++;
                end
            end
            if (wait0 > 4 || wait1 > 4) begin
                chk("starve_bound", 0, 1);
                p0 = 0; p1 = 0; wait0 = 0; wait1 = 0;
            end
        end
        idle(READ_LAT + 3);
        chk("drain0", q0.size(), 0);
        chk("drain1", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
